run_read_issuer: RTL and testbench
==================================

Name: run_read_issuer

Overview:
- Sits directly downstream of the multipass address calculator, between it and the per-channel AXI4 read masters feeding the merge tree leaves.
- On read_start, latches one start address per read channel plus a common run size, then issues 4 KB-safe AR bursts on every channel.
- Counts returning R bursts per channel.
- Pulses single_run_read_done back to the address calculator once every channel has received all data for the run.

Parameters:
- NUM_READ_CHANNELS, 4: number of independent read channels (merge tree leaves).
- C_M_AXI_ADDR_WIDTH, 64: AXI address width.
- C_XFER_SIZE_WIDTH, 32: width of the size field in bytes.
- C_BEAT_BYTES, 64: bytes per AXI data beat (512-bit bus); power of two.
- C_BURST_BYTES, 4096: max bytes per AR burst, equal to the boundary that bursts must not cross; power of two; at most 256 beats.
- C_MAX_OUTSTANDING, 16: max issued-but-incomplete bursts per channel.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: asynchronous active-low reset.
- read_start, in, 1: one-cycle pulse; latch addresses and size, start a run.
- read_addr, in, NUM_READ_CHANNELS x C_M_AXI_ADDR_WIDTH: per-channel start byte address.
- read_size_in_bytes, in, C_XFER_SIZE_WIDTH: bytes per channel for this run.
- m_arvalid, out, NUM_READ_CHANNELS: AR valid, per channel.
- m_arready, in, NUM_READ_CHANNELS: AR ready, per channel.
- m_araddr, out, NUM_READ_CHANNELS x C_M_AXI_ADDR_WIDTH: AR address.
- m_arlen, out, NUM_READ_CHANNELS x 8: beats-1.
- m_r_beat, in, NUM_READ_CHANNELS: per channel, rvalid&&rready observed by the data path.
- m_rlast, in, NUM_READ_CHANNELS: rlast qualified by m_r_beat.
- single_run_read_done, out, 1: one-cycle pulse when the run is complete.
- busy, out, 1: high from latch until the done pulse.

Behaviour:
- Reset: while aresetn is low, all state is cleared asynchronously. m_arvalid=0, m_araddr=0, m_arlen=0, single_run_read_done=0, busy=0; all FSMs go to IDLE.
- Top FSM states: IDLE, RUN, DONE.
  - IDLE + read_start: latch inputs; RUN next cycle; busy=1 from the cycle after read_start.
  - RUN → DONE when every channel reports complete.
  - DONE: single_run_read_done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- read_start while busy: ignored. The ignored pulse is not queued.
- Per-channel FSM states: IDLE, ISSUE, DRAIN, CPLT.
  - Latched size rounds up to whole beats: remaining_beats = ceil(size / C_BEAT_BYTES).
  - Burst length = min(remaining_beats, beats to next C_BURST_BYTES boundary from the current address). A burst never crosses the boundary.
  - m_arvalid first asserts the cycle after latch (ISSUE).
  - AR handshake (arvalid&&arready): address advances by len*C_BEAT_BYTES, remaining decrements, outstanding increments. Next burst can be presented the following cycle (one AR per cycle max).
  - m_arvalid deasserts when outstanding==C_MAX_OUTSTANDING.
  - Once m_arvalid is asserted, araddr and arlen are held stable until the handshake.
  - remaining==0 → DRAIN.
  - Each m_r_beat&&m_rlast decrements outstanding. The same-cycle AR handshake and rlast net to zero change.
  - DRAIN with outstanding==0 → CPLT.
- Size 0: channel goes straight to CPLT with no AR issued. If all channels are zero, single_run_read_done pulses 2 cycles after read_start.
- Latency: single_run_read_done pulses 1 cycle after the final rlast of the last-completing channel.
- read_addr must be C_BEAT_BYTES-aligned; the low bits are ignored (forced to 0).
- Counters are C_XFER_SIZE_WIDTH wide. Remaining-beat arithmetic never wraps for legal sizes.
- rlast with outstanding==0 is illegal; outstanding saturates at 0.
- Reset mid-run abandons the run. Bursts already in flight are not tracked after reset.

Optional Feature:
- Macro: RUN_READ_ISSUER_PERF_EN.
- Defined:
  - Adds output perf_run_cycles (32 bits). It loads with the cycle count from latch to done pulse, updated at each done pulse.
  - Adds output perf_dropped_starts (16 bits, saturating). It counts read_start pulses ignored while busy.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package run_read_pkg:
  - enum types for the top FSM and the channel FSM.
  - localparams for log2 beat bytes, log2 burst bytes, and max burst beats.
  - function computing beats to the next boundary.
- Sub-module run_read_chan: the per-channel burst splitter and outstanding counter, instantiated NUM_READ_CHANNELS times via generate. Its per-channel complete flag is ANDed in the top level.

Test Plan:
- Aligned run, size 16384 on all 4 channels, addr 0x0 / 0x4000 / 0x8000 / 0xC000, arready=1, immediate R → 4 ARs per channel, arlen=63; one done pulse after the last rlast.
- Unaligned start addr 0x0FC0, size 256 → two ARs: araddr=0x0FC0 arlen=0, then araddr=0x1000 arlen=2.
- Size 100 → rounds up to 2 beats, one AR with arlen=1.
- Size 0 on all channels → no arvalid; done pulse 2 cycles after read_start.
- arready held low for 10 cycles, then random; R returned with backpressure; 20 bursts needed per channel → outstanding never exceeds 16; araddr/arlen stable while arvalid&&!arready; exactly one done pulse.
- read_start pulsed again mid-run → ignored, one done pulse only (perf_dropped_starts=1 with macro defined); aresetn low mid-run → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/run_read_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_read_pkg
// Description : Shared types, constants and helpers for run_read_issuer.
//               - top_state_e  : run-level FSM (IDLE/RUN/DONE)
//               - chan_state_e : per-channel FSM (IDLE/ISSUE/DRAIN/CPLT)
//               - default beat/burst geometry constants
//               - beats_to_boundary() : beats left before the next burst
//                 boundary from a given byte address
// Revision    : 1.0 - initial release
// ============================================================================
package run_read_pkg;

    // Default geometry: 512-bit beats, 4 KB bursts / boundary.
    localparam int unsigned C_RR_BEAT_BYTES        = 64;
    localparam int unsigned C_RR_BURST_BYTES       = 4096;
    localparam int unsigned C_RR_LOG2_BEAT_BYTES   = $clog2(C_RR_BEAT_BYTES);
    localparam int unsigned C_RR_LOG2_BURST_BYTES  = $clog2(C_RR_BURST_BYTES);
    localparam int unsigned C_RR_MAX_BURST_BEATS   = C_RR_BURST_BYTES / C_RR_BEAT_BYTES;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_DONE = 2'd2
    } top_state_e;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DRAIN = 2'd2,
        CH_CPLT  = 2'd3
    } chan_state_e;

    // Number of whole beats between addr and the next 2**log2_burst byte
    // boundary. A boundary-aligned address yields a full burst. Result is
    // at most 256, hence 9 bits.
    function automatic logic [8:0] beats_to_boundary(
        input logic [63:0] addr,
        input int unsigned log2_beat,
        input int unsigned log2_burst
    );
        logic [63:0] burst_span;
        logic [63:0] offset;
        logic [63:0] beats;
        burst_span = 64'd1 << log2_burst;
        offset     = addr & (burst_span - 64'd1);
        beats      = (burst_span - offset) >> log2_beat;
        return beats[8:0];
    endfunction

endpackage : run_read_pkg
`default_nettype wire

// File: rtl/run_read_chan.sv
`default_nettype none
// ============================================================================
// Module      : run_read_chan
// Description : One read channel of run_read_issuer. Splits a latched
//               (address, size) pair into boundary-safe AR bursts, limits
//               the number of bursts in flight and counts returning R
//               bursts. Flags complete once all data has come back.
// Ports       : aclk/aresetn       - clock, async active-low reset
//               start              - latch start_addr/size_bytes (IDLE only)
//               clear              - return from CPLT to IDLE
//               start_addr         - run start byte address
//               size_bytes         - run size in bytes
//               m_arvalid/ready    - AR handshake
//               m_araddr/m_arlen   - AR address / beats-1
//               m_r_beat/m_rlast   - R beat and last-beat indication
//               complete           - all bursts issued and returned
// Revision    : 1.0 - initial release
// ============================================================================
module run_read_chan
    import run_read_pkg::*;
#(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned SIZE_W          = 32,
    parameter int unsigned BEAT_BYTES      = C_RR_BEAT_BYTES,
    parameter int unsigned BURST_BYTES     = C_RR_BURST_BYTES,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              clear,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [SIZE_W-1:0] size_bytes,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    input  logic              m_r_beat,
    input  logic              m_rlast,
    output logic              complete
);

    localparam int unsigned       C_LOG2_BEAT  = $clog2(BEAT_BYTES);
    localparam int unsigned       C_LOG2_BURST = $clog2(BURST_BYTES);
    localparam int unsigned       C_OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_OUT_W-1:0] C_OUT_MAX   = C_OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] C_ADDR_MASK  = ~ADDR_W'(BEAT_BYTES - 1);
    localparam logic [SIZE_W-1:0] C_BEAT_MASK  = SIZE_W'(BEAT_BYTES - 1);

    chan_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [SIZE_W-1:0]    rem_q, rem_d;
    logic [C_OUT_W-1:0]   out_q, out_d;

    logic [SIZE_W-1:0]    w_start_beats;
    logic [8:0]           w_btb;
    logic [8:0]           w_len;
    logic [SIZE_W-1:0]    w_rem_after;
    logic                 w_arvalid;
    logic                 w_ar_hs;
    logic                 w_rlast;

    // Round the byte count up to whole beats without a wider adder.
    assign w_start_beats = (size_bytes >> C_LOG2_BEAT)
                         + SIZE_W'(|(size_bytes & C_BEAT_MASK));

    assign w_btb       = beats_to_boundary(64'(addr_q), C_LOG2_BEAT, C_LOG2_BURST);
    assign w_len       = (rem_q < SIZE_W'(w_btb)) ? 9'(rem_q) : w_btb;
    assign w_rem_after = rem_q - SIZE_W'(w_len);

    // Address and length are pure functions of registered state, so they
    // stay put while arvalid waits for arready.
    assign w_arvalid = (state_q == CH_ISSUE) && (out_q != C_OUT_MAX);
    assign w_ar_hs   = w_arvalid && m_arready;
    // An rlast with nothing outstanding is illegal and simply dropped.
    assign w_rlast   = m_r_beat && m_rlast && (out_q != '0);

    assign m_arvalid = w_arvalid;
    assign m_araddr  = w_arvalid ? addr_q : '0;
    assign m_arlen   = w_arvalid ? 8'(w_len - 9'd1) : 8'd0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        out_d   = out_q;

        // Same-cycle AR issue and burst return cancel out.
        if (w_ar_hs && !w_rlast) begin
            out_d = out_q + C_OUT_W'(1);
        end else if (!w_ar_hs && w_rlast) begin
            out_d = out_q - C_OUT_W'(1);
        end

        case (state_q)
            CH_IDLE: begin
                if (start) begin
                    addr_d  = start_addr & C_ADDR_MASK;
                    rem_d   = w_start_beats;
                    out_d   = '0;
                    state_d = (w_start_beats == '0) ? CH_CPLT : CH_ISSUE;
                end
            end
            CH_ISSUE: begin
                if (w_ar_hs) begin
                    addr_d = addr_q + (ADDR_W'(w_len) << C_LOG2_BEAT);
                    rem_d  = w_rem_after;
                    if (w_rem_after == '0) begin
                        state_d = CH_DRAIN;
                    end
                end
            end
            CH_DRAIN: begin
                if (out_d == '0) begin
                    state_d = CH_CPLT;
                end
            end
            CH_CPLT: begin
                if (clear) begin
                    state_d = CH_IDLE;
                end
            end
            default: state_d = CH_IDLE;
        endcase
    end

    // complete looks ahead through the final rlast so the run-level done
    // pulse lands one cycle after that rlast.
    assign complete = (state_q == CH_CPLT)
                   || ((state_q == CH_DRAIN) && (out_d == '0));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= CH_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

endmodule : run_read_chan
`default_nettype wire

// File: rtl/run_read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : run_read_issuer
// Description : Latches one start address per read channel plus a common
//               run size, issues boundary-safe AR bursts on every channel,
//               tracks returning R bursts and pulses single_run_read_done
//               once every channel has all of its data.
// Ports       : aclk, aresetn              - clock, async active-low reset
//               read_start                 - start a run (ignored when busy)
//               read_addr[N][A]            - per-channel start byte address
//               read_size_in_bytes         - bytes per channel
//               m_arvalid/m_arready[N]     - per-channel AR handshake
//               m_araddr[N][A], m_arlen[N] - AR address / beats-1
//               m_r_beat[N], m_rlast[N]    - R beat / qualified rlast
//               single_run_read_done       - one-cycle run complete pulse
//               busy                       - run in progress
//               perf_run_cycles (32)       - latch-to-done cycles  (*)
//               perf_dropped_starts (16)   - ignored read_start count (*)
//               (*) present only with RUN_READ_ISSUER_PERF_EN defined
// Revision    : 1.0 - initial release
// ============================================================================
module run_read_issuer
    import run_read_pkg::*;
#(
    parameter int unsigned NUM_READ_CHANNELS  = 4,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_BEAT_BYTES       = C_RR_BEAT_BYTES,
    parameter int unsigned C_BURST_BYTES      = C_RR_BURST_BYTES,
    parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
    input  logic                                                  aclk,
    input  logic                                                  aresetn,
    input  logic                                                  read_start,
    input  logic [NUM_READ_CHANNELS-1:0][C_M_AXI_ADDR_WIDTH-1:0]  read_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                          read_size_in_bytes,
    output logic [NUM_READ_CHANNELS-1:0]                          m_arvalid,
    input  logic [NUM_READ_CHANNELS-1:0]                          m_arready,
    output logic [NUM_READ_CHANNELS-1:0][C_M_AXI_ADDR_WIDTH-1:0]  m_araddr,
    output logic [NUM_READ_CHANNELS-1:0][7:0]                     m_arlen,
    input  logic [NUM_READ_CHANNELS-1:0]                          m_r_beat,
    input  logic [NUM_READ_CHANNELS-1:0]                          m_rlast,
    output logic                                                  single_run_read_done,
`ifdef RUN_READ_ISSUER_PERF_EN
    output logic [31:0]                                           perf_run_cycles,
    output logic [15:0]                                           perf_dropped_starts,
`endif
    output logic                                                  busy
);

    top_state_e                     state_q, state_d;
    logic                           w_start_accept;
    logic                           w_clear;
    logic                           w_all_cplt;
    logic [NUM_READ_CHANNELS-1:0]   w_chan_cplt;

    assign w_start_accept = (state_q == TOP_IDLE) && read_start;
    assign w_clear        = (state_q == TOP_DONE);
    assign w_all_cplt     = &w_chan_cplt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TOP_IDLE: if (read_start) state_d = TOP_RUN;
            TOP_RUN:  if (w_all_cplt) state_d = TOP_DONE;
            TOP_DONE: state_d = TOP_IDLE;
            default:  state_d = TOP_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= TOP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign busy                 = (state_q == TOP_RUN);
    assign single_run_read_done = (state_q == TOP_DONE);

    generate
        for (genvar gi = 0; gi < NUM_READ_CHANNELS; gi++) begin : g_chan
            run_read_chan #(
                .ADDR_W          (C_M_AXI_ADDR_WIDTH),
                .SIZE_W          (C_XFER_SIZE_WIDTH),
                .BEAT_BYTES      (C_BEAT_BYTES),
                .BURST_BYTES     (C_BURST_BYTES),
                .MAX_OUTSTANDING (C_MAX_OUTSTANDING)
            ) u_chan (
                .aclk       (aclk),
                .aresetn    (aresetn),
                .start      (w_start_accept),
                .clear      (w_clear),
                .start_addr (read_addr[gi]),
                .size_bytes (read_size_in_bytes),
                .m_arvalid  (m_arvalid[gi]),
                .m_arready  (m_arready[gi]),
                .m_araddr   (m_araddr[gi]),
                .m_arlen    (m_arlen[gi]),
                .m_r_beat   (m_r_beat[gi]),
                .m_rlast    (m_rlast[gi]),
                .complete   (w_chan_cplt[gi])
            );
        end
    endgenerate

`ifdef RUN_READ_ISSUER_PERF_EN
    logic [31:0] run_cyc_q, run_cyc_d;
    logic [31:0] perf_run_cycles_q, perf_run_cycles_d;
    logic [15:0] dropped_q, dropped_d;

    // run_cyc counts from 1 in the first RUN cycle, so at the done pulse it
    // equals the distance from the read_start cycle.
    always_comb begin
        run_cyc_d         = run_cyc_q;
        perf_run_cycles_d = perf_run_cycles_q;
        dropped_d         = dropped_q;
        if (w_start_accept) begin
            run_cyc_d = 32'd1;
        end else if (state_q == TOP_RUN) begin
            run_cyc_d = run_cyc_q + 32'd1;
        end
        if (state_q == TOP_DONE) begin
            perf_run_cycles_d = run_cyc_q;
        end
        // Any start that is not accepted is lost; the counter saturates.
        if (read_start && (state_q != TOP_IDLE) && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run_cyc_q         <= '0;
            perf_run_cycles_q <= '0;
            dropped_q         <= '0;
        end else begin
            run_cyc_q         <= run_cyc_d;
            perf_run_cycles_q <= perf_run_cycles_d;
            dropped_q         <= dropped_d;
        end
    end

    assign perf_run_cycles     = perf_run_cycles_q;
    assign perf_dropped_starts = dropped_q;
`endif

endmodule : run_read_issuer
`default_nettype wire

// File: tb/tb_run_read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_read_issuer
// Description : Self-checking bench for run_read_issuer. Expected AR bursts
//               are computed from the run parameters when a run is started
//               and queued per channel; a responder returns R bursts for
//               each accepted AR and every handshake is checked against the
//               queue. Also checks hold-while-stalled, the outstanding cap,
//               done-pulse timing, ignored starts and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_read_issuer;

    localparam int NCH  = 4;
    localparam int AW   = 64;
    localparam int SW   = 32;
    localparam int MAXO = 16;

    logic                    aclk    = 1'b0;
    logic                    aresetn = 1'b1;
    logic                    read_start;
    logic [NCH-1:0][AW-1:0]  read_addr;
    logic [SW-1:0]           read_size_in_bytes;
    logic [NCH-1:0]          m_arvalid;
    logic [NCH-1:0]          m_arready;
    logic [NCH-1:0][AW-1:0]  m_araddr;
    logic [NCH-1:0][7:0]     m_arlen;
    logic [NCH-1:0]          m_r_beat;
    logic [NCH-1:0]          m_rlast;
    logic                    single_run_read_done;
    logic                    busy;
`ifdef RUN_READ_ISSUER_PERF_EN
    logic [31:0]             perf_run_cycles;
    logic [15:0]             perf_dropped_starts;
`endif

    run_read_issuer dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .read_start           (read_start),
        .read_addr            (read_addr),
        .read_size_in_bytes   (read_size_in_bytes),
        .m_arvalid            (m_arvalid),
        .m_arready            (m_arready),
        .m_araddr             (m_araddr),
        .m_arlen              (m_arlen),
        .m_r_beat             (m_r_beat),
        .m_rlast              (m_rlast),
        .single_run_read_done (single_run_read_done),
`ifdef RUN_READ_ISSUER_PERF_EN
        .perf_run_cycles      (perf_run_cycles),
        .perf_dropped_starts  (perf_dropped_starts),
`endif
        .busy                 (busy)
    );

    initial forever #5 aclk = ~aclk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t   exp_ar   [NCH][$];
    int    rq       [NCH][$];
    int    beat_cnt [NCH];
    int    model_out[NCH];
    bit    prev_pend[NCH];
    ar_t   prev_ar  [NCH];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int exp_done_cyc = 0;
    int ar_mode = 0;
    int ar_mode_start = 0;
    bit r_bp = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            exp_ar[c].delete();
            rq[c].delete();
            beat_cnt[c]  = 0;
            model_out[c] = 0;
            prev_pend[c] = 1'b0;
        end
    endtask

    function automatic int pending_count();
        int s = 0;
        for (int c = 0; c < NCH; c++) s += exp_ar[c].size() + rq[c].size();
        return s;
    endfunction

    // Reference burst split using divide arithmetic.
    task automatic push_expected(input int ch, input logic [63:0] a0, input longint unsigned size);
        logic [63:0]     a;
        longint unsigned rem, to_b, len;
        ar_t             e;
        a   = a0 & ~64'h3F;
        rem = (size + 64'd63) / 64'd64;
        while (rem != 0) begin
            to_b = (((a / 64'd4096) + 64'd1) * 64'd4096 - a) / 64'd64;
            len  = (rem < to_b) ? rem : to_b;
            e.addr = a;
            e.len  = 8'(len - 1);
            exp_ar[ch].push_back(e);
            a   = a + len * 64'd64;
            rem = rem - len;
        end
    endtask

    task automatic start_run(input logic [NCH-1:0][AW-1:0] addrs, input int unsigned size);
        @(negedge aclk);
        read_addr          = addrs;
        read_size_in_bytes = size;
        read_start         = 1'b1;
        for (int c = 0; c < NCH; c++) push_expected(c, addrs[c], size);
        ar_mode_start = cyc + 1;
        if (size == 0) exp_done_cyc = cyc + 2;
        @(negedge aclk);
        read_start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int exp_total, input int budget);
        int k = 0;
        while (n_done < exp_total && k < budget) begin
            @(negedge aclk);
            k++;
        end
        check("done_within_budget", (n_done >= exp_total), 1);
        repeat (5) @(negedge aclk);
        check("done_count", n_done, exp_total);
        check("busy_after_done", busy, 0);
        check("nothing_pending", pending_count(), 0);
    endtask

    // Responder / monitor: samples DUT outputs mid-cycle and drives arready
    // and R beats for the coming active edge.
    initial begin
        ar_t e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                clear_model();
                m_arready = '0;
                m_r_beat  = '0;
                m_rlast   = '0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (prev_pend[c]) begin
                        check("ar_hold_valid", m_arvalid[c], 1);
                        check("ar_hold_addr", m_araddr[c], prev_ar[c].addr);
                        check("ar_hold_len", m_arlen[c], prev_ar[c].len);
                    end
                    if (model_out[c] == MAXO) check("ar_outstanding_cap", m_arvalid[c], 0);
                end
                for (int c = 0; c < NCH; c++) begin
                    m_r_beat[c] = 1'b0;
                    m_rlast[c]  = 1'b0;
                    if (rq[c].size() != 0 && (!r_bp || $urandom_range(0, 1) == 1)) begin
                        m_r_beat[c] = 1'b1;
                        beat_cnt[c]++;
                        if (beat_cnt[c] == rq[c][0]) begin
                            m_rlast[c] = 1'b1;
                            void'(rq[c].pop_front());
                            beat_cnt[c] = 0;
                            model_out[c]--;
                            exp_done_cyc = cyc + 1;
                        end
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    if (ar_mode == 0) m_arready[c] = 1'b1;
                    else m_arready[c] = (cyc - ar_mode_start < 10) ? 1'b0 : 1'($urandom_range(0, 1));
                    if (m_arvalid[c] && m_arready[c]) begin
                        check("ar_expected", (exp_ar[c].size() != 0), 1);
                        if (exp_ar[c].size() != 0) begin
                            e = exp_ar[c].pop_front();
                            check("ar_addr", m_araddr[c], e.addr);
                            check("ar_len", m_arlen[c], e.len);
                        end
                        rq[c].push_back(int'(m_arlen[c]) + 1);
                        model_out[c]++;
                        prev_pend[c] = 1'b0;
                    end else begin
                        prev_pend[c]    = m_arvalid[c];
                        prev_ar[c].addr = m_araddr[c];
                        prev_ar[c].len  = m_arlen[c];
                    end
                end
                if (single_run_read_done) begin
                    n_done++;
                    check("done_cycle", cyc, exp_done_cyc);
                    check("done_nothing_pending", pending_count(), 0);
                end
            end
        end
    end

    initial begin
        logic [NCH-1:0][AW-1:0] addrs;
        read_start         = 1'b0;
        read_addr          = '0;
        read_size_in_bytes = '0;
        m_arready          = '0;
        m_r_beat           = '0;
        m_rlast            = '0;
        clear_model();

        // Reset state
        #1 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_araddr0", m_araddr[0], 0);
        check("rst_arlen0", m_arlen[0], 0);
        check("rst_busy", busy, 0);
        check("rst_done", single_run_read_done, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Aligned 16 KB per channel: 4 x 64-beat bursts each
        for (int c = 0; c < NCH; c++) addrs[c] = 64'(c) * 64'h4000;
        start_run(addrs, 16384);
        check("arvalid_first_cycle", m_arvalid, 4'hF);
        wait_done(1, 2000);

        // Unaligned start: one beat up to the 4 KB boundary, then three
        for (int c = 0; c < NCH; c++) addrs[c] = 64'(c) * 64'h10000 + 64'h0FC0;
        start_run(addrs, 256);
        wait_done(2, 500);

        // Size 0: no ARs, done two cycles after read_start
        for (int c = 0; c < NCH; c++) addrs[c] = 64'h2000;
        start_run(addrs, 0);
        check("size0_no_arvalid", m_arvalid, 0);
        wait_done(3, 50);

        // Stalled then random arready, random R backpressure, 20 bursts per
        // channel, plus one read_start while busy
        ar_mode = 1;
        r_bp    = 1'b1;
        for (int c = 0; c < NCH; c++) addrs[c] = 64'(c) * 64'h100000;
        start_run(addrs, 20 * 4096);
        repeat (200) @(negedge aclk);
        check("busy_before_dropped_start", busy, 1);
        for (int c = 0; c < NCH; c++) read_addr[c] = 64'h00F0_0000 + 64'(c) * 64'h1000;
        read_size_in_bytes = 32'd64;
        read_start = 1'b1;
        @(negedge aclk);
        read_start = 1'b0;
        wait_done(4, 20000);
`ifdef RUN_READ_ISSUER_PERF_EN
        check("perf_dropped_starts", perf_dropped_starts, 1);
`endif
        ar_mode = 0;
        r_bp    = 1'b0;

        // Reset mid-run: outputs clear immediately, run abandoned
        for (int c = 0; c < NCH; c++) addrs[c] = 64'(c) * 64'h4000;
        start_run(addrs, 16384);
        repeat (30) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("midrst_arvalid", m_arvalid, 0);
        check("midrst_araddr1", m_araddr[1], 0);
        check("midrst_arlen1", m_arlen[1], 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", single_run_read_done, 0);
        clear_model();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Size 100 rounds up to 2 beats: single AR with arlen 1
        for (int c = 0; c < NCH; c++) addrs[c] = 64'h8000 + 64'(c) * 64'h40;
        start_run(addrs, 100);
        wait_done(5, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_run_read_issuer
`default_nettype wire
